// File: rtl/biquad8_meter_pkg.sv
// Shared types and sizing helpers for the biquad8 power meter.
package biquad8_meter_pkg;

  localparam int NSAMP    = 8;
  localparam int PIPE_LAT = 5;

  typedef enum logic [1:0] {IDLE, TAG, DRAIN, DONE} meter_state_t;

  // Square of a signed n-bit value never exceeds 2^(2n-2), so 2n-1 bits suffice.
  function automatic int sq_bits(input int nbits);
    return 2 * nbits - 1;
  endfunction

  function automatic int tot_bits(input int nbits);
    return 2 * nbits + 2;
  endfunction

endpackage

// File: rtl/sample8_sumsq.sv
// Five-stage per-frame sum of squares and peak |x| over 8 lanes, with a tag
// bit carried alongside the data.
module sample8_sumsq
  import biquad8_meter_pkg::*;
#(
  parameter int NBITS  = 12,
  localparam int SQ_W  = sq_bits(NBITS),
  localparam int TOT_W = tot_bits(NBITS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NBITS*NSAMP-1:0] i_dat,
  input  logic                   i_tag,
  output logic                   o_tag,
  output logic                   o_tag_s4,
  output logic [TOT_W-1:0]       o_sum,
  output logic [NBITS-1:0]       o_peak
);

  logic [NBITS*NSAMP-1:0] r_s1_dat;
  logic [NBITS-1:0]       r_s2_abs [NSAMP];
  logic [SQ_W-1:0]        r_s2_sq  [NSAMP];
  logic [SQ_W:0]          r_s3_sum [NSAMP/2];
  logic [NBITS-1:0]       r_s3_pk  [NSAMP/2];
  logic [SQ_W+1:0]        r_s4_sum [2];
  logic [NBITS-1:0]       r_s4_pk  [2];
  logic [TOT_W-1:0]       r_s5_sum;
  logic [NBITS-1:0]       r_s5_pk;
  logic [5:1]             r_tag;

  logic signed [NBITS-1:0] w_x   [NSAMP];
  logic [NBITS-1:0]        w_abs [NSAMP];
  logic [SQ_W-1:0]         w_ext [NSAMP];
  logic [SQ_W-1:0]         w_sq  [NSAMP];

  // |most-negative| wraps to 2^(NBITS-1), which is still correct as unsigned.
  always_comb begin
    for (int j = 0; j < NSAMP; j++) begin
      w_x[j]   = r_s1_dat[NBITS*j +: NBITS];
      w_abs[j] = w_x[j][NBITS-1] ? NBITS'(-w_x[j]) : NBITS'(w_x[j]);
      w_ext[j] = SQ_W'(w_abs[j]);
      w_sq[j]  = w_ext[j] * w_ext[j];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[4:1], i_tag};
    end
  end

  always_ff @(posedge i_clk) begin
    r_s1_dat <= i_dat;
    for (int j = 0; j < NSAMP; j++) begin
      r_s2_abs[j] <= w_abs[j];
      r_s2_sq[j]  <= w_sq[j];
    end
    for (int j = 0; j < NSAMP/2; j++) begin
      r_s3_sum[j] <= {1'b0, r_s2_sq[2*j]} + {1'b0, r_s2_sq[2*j+1]};
      r_s3_pk[j]  <= (r_s2_abs[2*j] > r_s2_abs[2*j+1]) ? r_s2_abs[2*j] : r_s2_abs[2*j+1];
    end
    for (int j = 0; j < 2; j++) begin
      r_s4_sum[j] <= {1'b0, r_s3_sum[2*j]} + {1'b0, r_s3_sum[2*j+1]};
      r_s4_pk[j]  <= (r_s3_pk[2*j] > r_s3_pk[2*j+1]) ? r_s3_pk[2*j] : r_s3_pk[2*j+1];
    end
    r_s5_sum <= {1'b0, r_s4_sum[0]} + {1'b0, r_s4_sum[1]};
    r_s5_pk  <= (r_s4_pk[0] > r_s4_pk[1]) ? r_s4_pk[0] : r_s4_pk[1];
  end

  assign o_tag    = r_tag[5];
  assign o_tag_s4 = r_tag[4];
  assign o_sum    = r_s5_sum;
  assign o_peak   = r_s5_pk;

endmodule

// File: rtl/biquad8_power_meter.sv
// Windowed power and peak meter for the 8-lane biquad output: one result pair
// per window of 2^len frames, flagged by a single-cycle valid strobe.
module biquad8_power_meter
  import biquad8_meter_pkg::*;
#(
  parameter int NBITS        = 12,
  parameter int NSAMP        = 8,
  parameter int ACC_BITS     = 48,
  parameter int MAX_LOG2_LEN = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NBITS*NSAMP-1:0] dat_i,
  input  logic                   start_i,
  input  logic [4:0]             len_log2_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [ACC_BITS-1:0]    power_o,
  output logic [NBITS-1:0]       peak_o
);

  localparam int TOT_W = tot_bits(NBITS);

  if (ACC_BITS < TOT_W + MAX_LOG2_LEN) begin : g_acc_too_narrow
    $error("ACC_BITS too small for NBITS and MAX_LOG2_LEN");
  end
  if (NSAMP != 8) begin : g_bad_nsamp
    $error("adder tree is built for 8 lanes only");
  end

  meter_state_t            r_state;
  logic [MAX_LOG2_LEN-1:0] r_cnt;
  logic [ACC_BITS-1:0]     r_acc;
  logic [NBITS-1:0]        r_peak;
  logic                    r_busy;
  logic                    r_valid;
  logic [ACC_BITS-1:0]     r_power;
  logic [NBITS-1:0]        r_peak_out;

  logic [4:0]              w_len;
  logic [MAX_LOG2_LEN-1:0] w_cnt_init;
  logic                    w_accept;
  logic                    w_tag_in;
  logic                    w_s5_tag;
  logic                    w_s4_tag;
  logic [TOT_W-1:0]        w_sum;
  logic [NBITS-1:0]        w_frame_pk;
  logic [ACC_BITS-1:0]     w_acc_next;
  logic [NBITS-1:0]        w_pk_next;

  assign w_len      = (len_log2_i > 5'(MAX_LOG2_LEN)) ? 5'(MAX_LOG2_LEN) : len_log2_i;
  assign w_cnt_init = MAX_LOG2_LEN'((64'd1 << w_len) - 64'd1);
  assign w_accept   = start_i && !r_busy;
  // Frame 0 is tagged on accept; TAG then tags the remaining L-1 frames.
  assign w_tag_in   = w_accept || (r_state == TAG && r_cnt != '0);
  assign w_acc_next = r_acc + ACC_BITS'(w_sum);
  assign w_pk_next  = (w_frame_pk > r_peak) ? w_frame_pk : r_peak;

  sample8_sumsq #(.NBITS(NBITS)) u_sumsq (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_dat    (dat_i),
    .i_tag    (w_tag_in),
    .o_tag    (w_s5_tag),
    .o_tag_s4 (w_s4_tag),
    .o_sum    (w_sum),
    .o_peak   (w_frame_pk)
  );

  // Tags are contiguous, so a tagged S5 with an untagged S4 is the last frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_peak     <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_power    <= '0;
      r_peak_out <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_s5_tag) begin
        r_acc  <= w_acc_next;
        r_peak <= w_pk_next;
      end
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            r_state <= TAG;
            r_cnt   <= w_cnt_init;
            r_acc   <= '0;
            r_peak  <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        TAG: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= MAX_LOG2_LEN'(1)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_s5_tag && !w_s4_tag) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b1;
            r_power    <= w_acc_next;
            r_peak_out <= w_pk_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign valid_o = r_valid;
  assign power_o = r_power;
  assign peak_o  = r_peak_out;

  logic w_unused_accept;
  assign w_unused_accept = w_accept;

endmodule

// File: tb/tb_biquad8_power_meter.sv
// Randomised and directed bench for biquad8_power_meter against a window-level
// reference model.
module tb_biquad8_power_meter;

  localparam int NBITS        = 12;
  localparam int NSAMP        = 8;
  localparam int ACC_BITS     = 48;
  localparam int MAX_LOG2_LEN = 20;
  localparam int FW           = NBITS * NSAMP;

  logic                clock = 1'b0;
  logic                rstN;
  logic [FW-1:0]       dat;
  logic                start;
  logic [4:0]          lenLog2;
  logic                busy;
  logic                valid;
  logic [ACC_BITS-1:0] power;
  logic [NBITS-1:0]    peak;

  always #5 clock = ~clock;

  biquad8_power_meter #(
    .NBITS(NBITS), .NSAMP(NSAMP), .ACC_BITS(ACC_BITS), .MAX_LOG2_LEN(MAX_LOG2_LEN)
  ) dut (
    .clk_i      (clock),
    .rst_ni     (rstN),
    .dat_i      (dat),
    .start_i    (start),
    .len_log2_i (lenLog2),
    .busy_o     (busy),
    .valid_o    (valid),
    .power_o    (power),
    .peak_o     (peak)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one open window described by its start cycle and length
  bit     winActive  = 0;
  int     winStart   = 0;
  int     winLen     = 1;
  longint winPow     = 0;
  int     winPeak    = 0;
  longint heldPower  = 0;
  int     heldPeak   = 0;

  typedef struct {int at; longint pow; int pk;} dirExp_t;
  dirExp_t dirQ[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
    end
  endtask

  function automatic longint frameSq(input logic [FW-1:0] f);
    longint s = 0;
    for (int j = 0; j < NSAMP; j++) begin
      int x = $signed(f[NBITS*j +: NBITS]);
      s += longint'(x * x);
    end
    return s;
  endfunction

  function automatic int framePeak(input logic [FW-1:0] f);
    int m = 0;
    for (int j = 0; j < NSAMP; j++) begin
      int x = $signed(f[NBITS*j +: NBITS]);
      if (x < 0) x = -x;
      if (x > m) m = x;
    end
    return m;
  endfunction

  function automatic logic [FW-1:0] packAll(input int v);
    logic [FW-1:0] f;
    for (int j = 0; j < NSAMP; j++) f[NBITS*j +: NBITS] = NBITS'(v);
    return f;
  endfunction

  function automatic logic [FW-1:0] randFrame();
    logic [FW-1:0] f;
    for (int j = 0; j < NSAMP; j++) begin
      if ($urandom_range(0, 9) == 0) f[NBITS*j +: NBITS] = 12'h800;
      else                           f[NBITS*j +: NBITS] = NBITS'($urandom);
    end
    return f;
  endfunction

  // Drive one cycle, check the DUT against the model, then advance the model
  task automatic applyStimulus(input bit rstn, input bit st, input logic [4:0] ln, input logic [FW-1:0] f);
    bit expBusy;
    bit expValid;
    int effLen;
    rstN    = rstn;
    start   = st;
    lenLog2 = ln;
    dat     = f;
    @(negedge clock);
    expBusy  = winActive && cyc >= winStart + 1 && cyc <= winStart + winLen + 4;
    expValid = winActive && cyc == winStart + winLen + 5;
    if (expValid) begin
      heldPower = winPow;
      heldPeak  = winPeak;
    end
    checkOutput("busy",  64'(busy),  64'(expBusy));
    checkOutput("valid", 64'(valid), 64'(expValid));
    checkOutput("power", 64'(power), 64'(heldPower));
    checkOutput("peak",  64'(peak),  64'(heldPeak));
    foreach (dirQ[k]) begin
      if (dirQ[k].at == cyc) begin
        checkOutput("dir_valid", 64'(valid), 64'd1);
        checkOutput("dir_power", 64'(power), 64'(dirQ[k].pow));
        checkOutput("dir_peak",  64'(peak),  64'(dirQ[k].pk));
      end
    end
    if (!rstn) begin
      winActive = 0;
      heldPower = 0;
      heldPeak  = 0;
    end else begin
      if (st && !expBusy) begin
        effLen    = (ln > 5'(MAX_LOG2_LEN)) ? MAX_LOG2_LEN : int'(ln);
        winActive = 1;
        winStart  = cyc;
        winLen    = 1 << effLen;
        winPow    = 0;
        winPeak   = 0;
      end
      if (winActive && cyc >= winStart && cyc < winStart + winLen) begin
        winPow += frameSq(f);
        if (framePeak(f) > winPeak) winPeak = framePeak(f);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 5'($urandom), randFrame());
  endtask

  initial begin
    logic [FW-1:0] imp;
    rstN    = 1'b0;
    start   = 1'b0;
    lenLog2 = '0;
    dat     = '0;
    repeat (2) @(posedge clock);
    #1;
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 1, 3, '0);
    idleCycles(3);

    // All lanes 100, window of 16 frames
    dirQ.push_back('{cyc + 21, 64'd1280000, 100});
    for (int i = 0; i < 25; i++) applyStimulus(1, i == 0, 5'd4, packAll(100));
    idleCycles(4);

    // Single impulse inside, then outside, an 8-frame window
    for (int pass = 0; pass < 2; pass++) begin
      imp = '0;
      imp[3*NBITS +: NBITS] = 12'(-1000);
      if (pass == 0) dirQ.push_back('{cyc + 13, 64'd1000000, 1000});
      else           dirQ.push_back('{cyc + 13, 64'd0, 0});
      for (int i = 0; i < 16; i++)
        applyStimulus(1, i == 0, 5'd3, (i == (pass == 0 ? 2 : 8)) ? imp : '0);
      idleCycles(2);
    end

    // Starts at 0, 3 (ignored) and 9 (valid cycle) with len 2
    dirQ.push_back('{cyc + 9,  64'd32, 1});
    dirQ.push_back('{cyc + 18, 64'd32, 1});
    for (int i = 0; i < 22; i++) applyStimulus(1, i == 0 || i == 3 || i == 9, 5'd2, packAll(1));
    idleCycles(3);

    // Reset in cycle 4 of a len=3 window
    for (int i = 0; i < 25; i++) applyStimulus(i != 4, i == 0, 5'd3, packAll(50));

    // Back-to-back len=0 windows with a ramp, restart in each valid cycle
    for (int i = 0; i < 36; i++) begin
      logic [FW-1:0] ramp;
      for (int j = 0; j < NSAMP; j++) ramp[NBITS*j +: NBITS] = NBITS'(cyc * 8 + j * 37);
      applyStimulus(1, (i % 6) == 0 && i < 30, 5'd0, ramp);
    end
    idleCycles(2);

    // Oversized exponent: window must still be open long after small lengths end
    for (int i = 0; i < 300; i++) applyStimulus(1, i == 0, 5'd25, packAll(-2048));
    applyStimulus(0, 0, 0, '0);
    idleCycles(2);

    // Randomised windows, starts and occasional resets
    for (int i = 0; i < 2500; i++)
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0,
                    5'($urandom_range(0, 6)), randFrame());
    idleCycles(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/biquad8_power_meter.md
Name: biquad8_power_meter

Overview:
Downstream consumer of the 8-sample-per-clock biquad filter output. Over a programmable window of 2^len clocks, it accumulates the sum of squares of every lane and tracks the peak absolute value. It returns one result word pair per window with a single-cycle valid strobe. Used to measure filter response and stopband power, and to qualify coefficient sets written over the wishbone bus.

Parameters:
NBITS, 12, signed sample width per lane (matches filter OUTBITS)
NSAMP, 8, samples per clock
ACC_BITS, 48, accumulator/result width
MAX_LOG2_LEN, 20, largest allowed window exponent

Ports:
clk_i  in  1  sample clock (same clock as filter clk_i)
rst_ni  in  1  reset; synchronous, active-low
dat_i  in  NBITS*NSAMP  packed samples, lane j at [NBITS*j +: NBITS], two's complement
start_i  in  1  begin a window; sampled only when busy_o=0
len_log2_i  in  5  window exponent; latched on accepted start
busy_o  out  1  window or drain in progress
valid_o  out  1  one-cycle strobe, results updated
power_o  out  ACC_BITS  unsigned sum over window of all lane squares
peak_o  out  NBITS  unsigned max |sample| over window

Behaviour:
- One clock and one reset, as already decided. Reset is synchronous and active-low. While rst_ni=0: busy_o=0, valid_o=0, power_o=0, peak_o=0, state=IDLE, all pipeline tags cleared.
- Accepted start: start_i=1 and busy_o=0 in cycle 0.
  - len = min(len_log2_i, MAX_LOG2_LEN), latched in cycle 0.
  - L = 2^len frames are tagged: the dat_i frames present in cycles 0..L-1.
- Pipeline stages, each one register:
  - S1: input capture plus tag.
  - S2: per-lane |x| and x^2. The square is unsigned 2*NBITS-1 bits; (-2048)^2 = 2^22.
  - S3: 4 pairwise sums.
  - S4: 2 sums.
  - S5: lane total, 2*NBITS+2 bits, plus frame peak.
  - The tag travels with the data. Only tagged S5 entries are accumulated into acc and peak.
- Accumulation: acc and peak are cleared on accept. The last frame's contribution is folded in at the end of cycle L+4.
- Result timing:
  - valid_o=1 in exactly cycle L+5.
  - power_o and peak_o update in that same cycle and then hold until the next valid_o.
- busy_o: 1 in cycles 1..L+4, 0 in cycle L+5. A new start in cycle L+5 is accepted.
- start_i while busy_o=1 is ignored, with no effect on the window or len.
- FSM:
  - IDLE -(accept)-> TAG.
  - TAG counts L frames -> DRAIN.
  - DRAIN waits until the last tag leaves S5 -> DONE.
  - DONE asserts valid_o for one cycle -> IDLE.
  - When L=1, TAG lasts one cycle.
- Widths:
  - No saturation is needed: the worst case is 8 * 2^22 * 2^20 = 2^45 < 2^48.
  - Synthesis must check ACC_BITS >= 2*NBITS+2+MAX_LOG2_LEN.
  - |most-negative| = 2^(NBITS-1) fits unsigned NBITS.
- Reset mid-window: all in-flight tags are discarded, with no valid_o and outputs 0 on the next cycle. A new start is accepted the cycle after rst_ni returns to 1.
- Untagged frames have no effect. dat_i is captured every cycle regardless.

Decomposition:
- Package biquad8_meter_pkg holds:
  - NSAMP
  - PIPE_LAT=5
  - the state typedef (IDLE, TAG, DRAIN, DONE)
  - the width function for the square/lane-total sizes
- One sub-module, sample8_sumsq: pipelined S1-S5 per-lane square/abs, adder tree and frame max with tag passthrough. It holds no state beyond the pipeline.
- The top holds the FSM, window counter, accumulator and output registers.

Test Plan:
- All lanes constant 100, len=4, start in cycle 0 -> valid_o exactly in cycle 21; power_o=1,280,000 (16*8*10000); peak_o=100; busy_o high cycles 1..20.
- Lane 3 = -1000 for one frame (cycle 2), else 0, len=3 -> power_o=1,000,000, peak_o=1000. Repeating with the impulse in cycle 8 (outside the window) -> power_o=0, peak_o=0.
- All lanes -2048, len_log2_i=25 (clamped to 20) -> valid_o in cycle 2^20+5; power_o=2^45, peak_o=2048.
- start_i pulsed in cycles 0, 3 and 9 with len=2, constant 1 on all lanes -> cycle 3 start ignored; first valid in cycle 9 with power_o=32; cycle 9 start accepted; second valid in cycle 18 with power_o=32.
- rst_ni=0 during cycle 4 of a len=3 window -> from cycle 5 busy_o=0, power_o=0, peak_o=0; no valid_o in the following 20 cycles.
- Back-to-back windows with the start in the valid_o cycle, len=0, ramp input -> each valid_o is 6 cycles after its start and power_o equals the single tagged frame's square sum.
